// File: rtl/data_mem_arbiter.sv
// Shares one synchronous-read data-memory port between the processor
// (read/write) and the VGA frame fetcher (read only). VGA wins ties until
// the CPU has waited through STARVE_LIMIT VGA grants. The CPU then gets the
// next slot. Read data returns one cycle after the grant and is routed only
// to the requester that issued the read.
//
// Handshake: a requester raises *_req with a stable address (and we/wdata
// for the CPU). It holds them until *_gnt is high. In that cycle the access
// is issued to memory. A granted read answers with a single-cycle *_rvalid
// pulse on the next cycle. *_rdata is meaningful only while *_rvalid is high.
module data_mem_arbiter #(
  parameter int bus          = 32,
  parameter int addrw        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [addrw-1:0] cpu_addr,
  input  logic [bus-1:0]   cpu_wdata,
  output logic             cpu_gnt,
  output logic [bus-1:0]   cpu_rdata,
  output logic             cpu_rvalid,
  input  logic             vga_req,
  input  logic [addrw-1:0] vga_addr,
  output logic             vga_gnt,
  output logic [bus-1:0]   vga_rdata,
  output logic             vga_rvalid,
  output logic [addrw-1:0] mem_addr,
  output logic [bus-1:0]   mem_wdata,
  output logic             mem_re,
  output logic             mem_we,
  input  logic [bus-1:0]   mem_rdata
);

  // Wide enough to hold STARVE_LIMIT itself, because the counter saturates there.
  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // Owner of the read that is currently in flight.
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_VGA  = 2'd2;

  logic [CW-1:0] starve_cnt;
  logic [1:0]    rd_owner;
  logic          cpu_win;
  logic          vga_win;

  // Pick the winner for this cycle. Nothing is granted while reset is high.
  always_comb begin
    cpu_win = 1'b0;
    vga_win = 1'b0;
    if (!reset) begin
      if (cpu_req && vga_req) begin
        if (starve_cnt >= LIMIT) cpu_win = 1'b1;
        else                     vga_win = 1'b1;
      end else begin
        cpu_win = cpu_req;
        vga_win = vga_req;
      end
    end
  end

  assign cpu_gnt   = cpu_win;
  assign vga_gnt   = vga_win;
  assign mem_wdata = cpu_wdata;

  // Drive the single memory port from the winner. The bus idles at zero.
  always_comb begin
    mem_addr = '0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    if (cpu_win) begin
      mem_addr = cpu_addr;
      mem_we   = cpu_we;
      mem_re   = !cpu_we;
    end else if (vga_win) begin
      mem_addr = vga_addr;
      mem_re   = 1'b1;
    end
  end

  // Count VGA grants taken while the CPU waits. Clear once the CPU is served or stops asking.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (cpu_win || !cpu_req) begin
      starve_cnt <= '0;
    end else if (vga_win && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Remember who issued this cycle's read so the next cycle's data goes back to them.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner <= OWN_NONE;
    end else if (cpu_win && !cpu_we) begin
      rd_owner <= OWN_CPU;
    end else if (vga_win) begin
      rd_owner <= OWN_VGA;
    end else begin
      rd_owner <= OWN_NONE;
    end
  end

  // Reset drops an in-flight read immediately, including during the reset cycle itself.
  assign cpu_rvalid = !reset && (rd_owner == OWN_CPU);
  assign vga_rvalid = !reset && (rd_owner == OWN_VGA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign vga_rdata  = vga_rvalid ? mem_rdata : '0;

endmodule
